mul_issue_ctrl: RTL and testbench
=================================

Name: mul_issue_ctrl

Overview:
- Execute-stage controller that sits directly upstream of the team's 5-cycle Booth/Wallace multiplier and also consumes its result.
- Accepts one RV64M multiply request at a time from the EXU: MUL, MULH, MULHSU, MULHU, MULW.
- Selects the signedness mode, holds operands stable for the multiplier, picks the hi or lo half, and sign-extends the W result.
- Returns the result to the pipeline over a valid/ready handshake, with flush and watchdog handling.

Parameters:
- MUL_LAT, 5: multiplier cycles from mul_valid_in to mul_valid_out (informational; the controller waits for mul_valid_out).
- WDOG, 15: cycles spent in BUSY or DRAIN without mul_valid_out before forced recovery.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW, 5-7 illegal
- req_src1  in  64  rs1 (multiplicand)
- req_src2  in  64  rs2 (multiplier)
- flush  in  1  pipeline kill
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts result
- resp_data  out  64  result
- resp_err  out  1  watchdog timeout or illegal op
- mul_valid_in  out  1  one-cycle start pulse to the multiplier
- mul_signed  out  2  00 unsigned x unsigned, 01 signed x unsigned, 10 signed x signed (same values as the shared multiplier defines)
- mul_multiplicand  out  64  registered operand
- mul_multiplier  out  64  registered operand
- mul_valid_out  in  1  multiplier done pulse
- mul_result_hi  in  64  product bits [127:64]
- mul_result_lo  in  64  product bits [63:0]

Behaviour:
- Reset: state IDLE; req_ready=1; resp_valid=0; resp_data=0; resp_err=0; mul_valid_in=0; mul_signed=00; operand registers=0; watchdog counter=0.
- States: IDLE, BUSY, DONE, DRAIN.
  - req_ready=1 only in IDLE with flush=0.
  - resp_valid=1 only in DONE.
- IDLE:
  - Accept when req_valid & req_ready.
  - On accept, register operands, op and mul_signed. Mapping: MUL, MULH, MULW -> 10; MULHSU -> 01; MULHU -> 00.
  - Valid op: assert mul_valid_in for exactly the next cycle and enter BUSY.
  - Illegal op: do not start the multiplier; enter DONE with resp_data=0 and resp_err=1.
- BUSY:
  - Operands and mul_signed stay constant.
  - Watchdog counts up from 0.
  - On mul_valid_out, latch resp_data and enter DONE:
    - MUL: lo
    - MULH, MULHSU, MULHU: hi
    - MULW: {32{lo[31]}, lo[31:0]}
  - If the watchdog reaches WDOG: enter DONE with resp_data=0 and resp_err=1.
- DONE:
  - Hold resp_data and resp_err until resp_ready.
  - resp_valid & resp_ready -> IDLE; resp_err clears on exit.
- DRAIN:
  - Entered on flush in BUSY; the multiplier has no kill input, so the in-flight result must be absorbed.
  - Stay until mul_valid_out or watchdog expiry, then IDLE with no response.
- Latency: request accepted at edge T; mul_valid_in high in cycle T+1; mul_valid_out in cycle T+1+MUL_LAT; resp_valid from cycle T+2+MUL_LAT. A new request is accepted no earlier than the cycle after the handshake.
- Flush:
  - IDLE: nothing is accepted that cycle.
  - BUSY: go to DRAIN, including when mul_valid_out arrives in the same cycle; in that case the result is discarded and the next state is IDLE.
  - DONE: drop the result, go to IDLE; flush has priority over resp_ready.
  - DRAIN: no additional effect.
- mul_valid_out outside BUSY/DRAIN is ignored.
- The controller never raises mul_valid_in while a multiply is outstanding.
- Reset mid-operation: everything returns to reset values immediately. The multiplier shares rst, so no drain is needed.

Test Plan:
- MUL, src1=3, src2=-5 -> mul_signed=10, mul_valid_in 1 cycle after accept, resp_data=0xFFFFFFFFFFFFFFF1 exactly MUL_LAT+2 cycles after accept, resp_err=0.
- MULH/MULHSU/MULHU, src1=0xFFFFFFFFFFFFFFFF, src2=2 -> 0xFFFFFFFFFFFFFFFF / 0xFFFFFFFFFFFFFFFF / 0x0000000000000001.
- MULW, src1=0x0000000080000000, src2=1 -> resp_data=0xFFFFFFFF80000000.
- resp_ready held low 10 cycles after a result, then high -> resp_data stable throughout, req_ready=0 until the handshake, next request accepted the cycle after.
- Flush 2 cycles after accept -> no resp_valid, mul_valid_out absorbed in DRAIN, req_ready=1 the cycle after it; a following MUL 7x6 returns 42.
- Illegal op=6 -> DONE the next cycle, resp_data=0, resp_err=1, no mul_valid_in; a stubbed multiplier that never answers -> resp_err=1 after WDOG cycles; async rst pulse mid-BUSY -> all outputs at reset values immediately.

Source files
------------

// File: rtl/mul_issue_ctrl_if.sv
// Handshake and multiplier bus for the execute-stage multiply controller.
// slave = controller side, master = pipeline plus multiplier side.
interface mul_issue_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [63:0] req_src1;
    logic [63:0] req_src2;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        resp_err;
    logic        mul_valid_in;
    logic [1:0]  mul_signed;
    logic [63:0] mul_multiplicand;
    logic [63:0] mul_multiplier;
    logic        mul_valid_out;
    logic [63:0] mul_result_hi;
    logic [63:0] mul_result_lo;

    modport slave (
        input  req_valid, req_op, req_src1, req_src2,
        input  flush, resp_ready,
        input  mul_valid_out, mul_result_hi, mul_result_lo,
        output req_ready, resp_valid, resp_data, resp_err,
        output mul_valid_in, mul_signed,
        output mul_multiplicand, mul_multiplier
    );

    modport master (
        output req_valid, req_op, req_src1, req_src2,
        output flush, resp_ready,
        output mul_valid_out, mul_result_hi, mul_result_lo,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  mul_valid_in, mul_signed,
        input  mul_multiplicand, mul_multiplier
    );
endinterface

// File: rtl/mul_issue_ctrl.sv
// RV64M multiply issue controller: starts the shared multiplier,
// selects the result half and returns it, with flush and watchdog.
module mul_issue_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int WDOG    = 15
) (
    input logic           clk,
    input logic           rst,
    mul_issue_ctrl_if.slave bus
);
    // A watchdog shorter than the multiplier would kill healthy ops.
    localparam int WLIM = (WDOG > MUL_LAT) ? WDOG : MUL_LAT + 1;
    localparam int WW   = $clog2(WLIM + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [63:0] src1_q, src1_d;
    logic [63:0] src2_q, src2_d;
    logic [1:0]  sgn_q, sgn_d;
    logic        start_q, start_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic [63:0] data_q, data_d;
    logic        err_q, err_d;

    logic        accept;
    logic        legal;
    logic        expired;
    logic [1:0]  sgn_map;
    logic [63:0] result;

    assign accept  = (state_q == S_IDLE) && !bus.flush
                     && bus.req_valid;
    assign legal   = (bus.req_op <= 3'd4);
    assign expired = (wdog_q >= WW'(WLIM - 1));

    // Operand signedness and result-half selection.
    always_comb begin
        sgn_map = 2'b10;
        case (bus.req_op)
            3'd2:    sgn_map = 2'b01;
            3'd3:    sgn_map = 2'b00;
            default: sgn_map = 2'b10;
        endcase
        result = bus.mul_result_hi;
        case (op_q)
            3'd0:    result = bus.mul_result_lo;
            3'd4:    result = {{32{bus.mul_result_lo[31]}},
                               bus.mul_result_lo[31:0]};
            default: result = bus.mul_result_hi;
        endcase
    end

    // Next-state and register updates.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        sgn_d   = sgn_q;
        start_d = 1'b0;
        wdog_d  = wdog_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = bus.req_op;
                    src1_d = bus.req_src1;
                    src2_d = bus.req_src2;
                    sgn_d  = sgn_map;
                    wdog_d = '0;
                    if (legal) begin
                        start_d = 1'b1;
                        state_d = S_BUSY;
                    end else begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                if (bus.flush) begin
                    wdog_d  = wdog_q + 1'b1;
                    state_d = bus.mul_valid_out ? S_IDLE : S_DRAIN;
                end else if (bus.mul_valid_out) begin
                    data_d  = result;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (expired) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_DONE: begin
                if (bus.flush || bus.resp_ready) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (bus.mul_valid_out || expired) begin
                    state_d = S_IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            sgn_q   <= '0;
            start_q <= 1'b0;
            wdog_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            sgn_q   <= sgn_d;
            start_q <= start_d;
            wdog_q  <= wdog_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready        = (state_q == S_IDLE) && !bus.flush;
    assign bus.resp_valid       = (state_q == S_DONE);
    assign bus.resp_data        = data_q;
    assign bus.resp_err         = err_q;
    assign bus.mul_valid_in     = start_q;
    assign bus.mul_signed       = sgn_q;
    assign bus.mul_multiplicand = src1_q;
    assign bus.mul_multiplier   = src2_q;
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: directed cases plus random ops against
// an arithmetic reference model and a behavioural multiplier stub.
module tb_mul_issue_ctrl;
    localparam int MUL_LAT = 5;
    localparam int WDOG    = 15;

    logic clk = 1'b0;
    logic rst;
    logic mute;
    int   tests = 0;
    int   fails = 0;
    int   starts = 0;

    always #5 clk = ~clk;

    mul_issue_ctrl_if bus ();

    mul_issue_ctrl #(
        .MUL_LAT(MUL_LAT),
        .WDOG(WDOG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // Multiplier stub: fixed latency pipe, product from held operands.
    logic [MUL_LAT-1:0] pipe;
    logic [127:0]       ea, eb, prod;

    always @(posedge clk or posedge rst) begin
        if (rst) pipe <= '0;
        else     pipe <= {pipe[MUL_LAT-2:0], bus.mul_valid_in};
    end

    always @(posedge clk) begin
        if (bus.mul_valid_in) starts <= starts + 1;
    end

    always_comb begin
        ea = {64'b0, bus.mul_multiplicand};
        eb = {64'b0, bus.mul_multiplier};
        if (bus.mul_signed[1] || bus.mul_signed[0])
            ea[127:64] = {64{bus.mul_multiplicand[63]}};
        if (bus.mul_signed == 2'b10)
            eb[127:64] = {64{bus.mul_multiplier[63]}};
        prod = ea * eb;
    end

    assign bus.mul_valid_out = pipe[MUL_LAT-1] & ~mute;
    assign bus.mul_result_hi = prod[127:64];
    assign bus.mul_result_lo = prod[63:0];

    // Reference: {err, data} straight from the RV64M definitions.
    function automatic logic [64:0] model(input logic [2:0] op,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
        logic signed [127:0] p;
        logic [127:0]        u;
        u = {64'b0, a} * {64'b0, b};
        case (op)
            3'd0: return {1'b0, u[63:0]};
            3'd1: begin
                p = $signed(a) * $signed(b);
                return {1'b0, p[127:64]};
            end
            3'd2: begin
                p = $signed(a) * $signed({1'b0, b});
                return {1'b0, p[127:64]};
            end
            3'd3: return {1'b0, u[127:64]};
            3'd4: return {1'b0, {32{u[31]}}, u[31:0]};
            default: return {1'b1, 64'b0};
        endcase
    endfunction

    function automatic logic [1:0] exp_sgn(input logic [2:0] op);
        if (op == 3'd2) return 2'b01;
        if (op == 3'd3) return 2'b00;
        return 2'b10;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_data", bus.resp_data, 64'd0);
        chk("rst_resp_err", 64'(bus.resp_err), 64'd0);
        chk("rst_mul_valid_in", 64'(bus.mul_valid_in), 64'd0);
        chk("rst_mul_signed", 64'(bus.mul_signed), 64'd0);
        chk("rst_mcand", bus.mul_multiplicand, 64'd0);
        chk("rst_mplier", bus.mul_multiplier, 64'd0);
    endtask

    // Issue one request at a negedge in IDLE and retire it.
    task automatic run_op(input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input int hold);
        logic [64:0] m;
        logic [63:0] d0;
        logic        exp_err;
        int          cyc, s0, exp_lat;
        logic        stable;
        m       = model(op, a, b);
        exp_err = m[64] | mute;
        exp_lat = m[64] ? 1 : (mute ? WDOG + 1 : MUL_LAT + 2);
        s0      = starts;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_src1  = a;
        bus.req_src2  = b;
        #1 chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("start_pulse", 64'(bus.mul_valid_in), 64'(!m[64]));
        if (!m[64]) begin
            chk("mul_signed", 64'(bus.mul_signed), 64'(exp_sgn(op)));
            chk("mcand", bus.mul_multiplicand, a);
            chk("mplier", bus.mul_multiplier, b);
        end
        cyc = 1;
        while (!bus.resp_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", 64'(cyc), 64'(exp_lat));
        chk("resp_data", bus.resp_data, exp_err ? 64'd0 : m[63:0]);
        chk("resp_err", 64'(bus.resp_err), 64'(exp_err));
        chk("start_count", 64'(starts - s0), 64'(!m[64]));
        d0     = bus.resp_data;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.resp_data !== d0 || bus.resp_valid !== 1'b1 ||
                bus.req_ready !== 1'b0)
                stable = 1'b0;
        end
        if (hold > 0) chk("hold_stable", 64'(stable), 64'd1);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        #1;
        chk("post_valid", 64'(bus.resp_valid), 64'd0);
        chk("post_err", 64'(bus.resp_err), 64'd0);
        chk("post_ready", 64'(bus.req_ready), 64'd1);
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 3))
            0:       return '1;
            1:       return 64'h8000_0000_0000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [2:0] op;
        logic       seen_v;
        logic       seen_r;
        int         s0;
        rst            = 1'b1;
        mute           = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_op     = '0;
        bus.req_src1   = '0;
        bus.req_src2   = '0;
        bus.flush      = 1'b0;
        bus.resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;
        @(negedge clk);

        run_op(3'd0, 64'd3, -64'sd5, 0);
        run_op(3'd1, '1, 64'd2, 0);
        run_op(3'd2, '1, 64'd2, 0);
        run_op(3'd3, '1, 64'd2, 0);
        run_op(3'd4, 64'h8000_0000, 64'd1, 0);
        run_op(3'd0, 64'd12345, 64'd678, 10);

        // Flush two cycles after accept: result absorbed silently.
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd0;
        bus.req_src1  = 64'd9;
        bus.req_src2  = 64'd9;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        seen_v = 1'b0;
        seen_r = 1'b0;
        for (int c = 3; c <= MUL_LAT + 1; c++) begin
            seen_v |= bus.resp_valid;
            seen_r |= bus.req_ready;
            @(negedge clk);
        end
        chk("drain_no_resp", 64'(seen_v | bus.resp_valid), 64'd0);
        chk("drain_wait", 64'(seen_r), 64'd0);
        chk("drain_exit", 64'(bus.req_ready), 64'd1);
        run_op(3'd0, 64'd7, 64'd6, 0);

        // Flush in the same cycle the multiplier answers.
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (MUL_LAT) @(negedge clk);
        chk("coinc_mvo", 64'(bus.mul_valid_out), 64'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        chk("coinc_idle", 64'(bus.req_ready), 64'd1);
        chk("coinc_no_resp", 64'(bus.resp_valid), 64'd0);

        // Flush while a result waits in DONE.
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd3;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (MUL_LAT + 1) @(negedge clk);
        chk("done_valid", 64'(bus.resp_valid), 64'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        chk("done_flush", 64'(bus.resp_valid), 64'd0);
        chk("done_flush_rdy", 64'(bus.req_ready), 64'd1);

        // Flush in IDLE blocks acceptance.
        s0 = starts;
        bus.req_valid = 1'b1;
        bus.flush     = 1'b1;
        #1 chk("idle_flush_rdy", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        @(negedge clk);
        chk("idle_flush_none", 64'(starts - s0), 64'd0);
        chk("idle_flush_state", 64'(bus.req_ready), 64'd1);

        run_op(3'd6, 64'd1, 64'd1, 0);
        mute = 1'b1;
        run_op(3'd0, 64'd5, 64'd5, 0);
        mute = 1'b0;

        // Asynchronous reset in the middle of BUSY.
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd0;
        bus.req_src1  = 64'hdead;
        bus.req_src2  = 64'hbeef;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1 chk_reset_vals();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 5));
            if (op == 3'd5) op = 3'd7;
            run_op(op, rnd64(), rnd64(), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
